// File: rtl/gbt_rx_pattern_checker.sv
// rtl/gbt_rx_pattern_checker.sv - GBT RX counter-pattern checker with lock FSM and error/frame counters
package gbt_rx_pkg;
    typedef struct packed {
        logic clk;
        logic reset;
    } ckrs_t;
endpackage

module gbt_rx_pattern_checker
    import gbt_rx_pkg::*;
#(
    parameter int LOCK_COUNT = 16,
    parameter int LOSS_COUNT = 4,
    parameter int ERRCNT_W   = 32,
    parameter int FRAMECNT_W = 48
) (
    input  ckrs_t                  ClkRs_ix,
    input  logic [83:0]            rx_frame_ib84,
    input  logic                   rx_valid_i,
    input  logic                   rx_ready_i,
    input  logic                   clear_i,
    output logic                   locked_o,
    output logic                   error_o,
    output logic [ERRCNT_W-1:0]    err_cnt_ob,
    output logic [FRAMECNT_W-1:0]  frame_cnt_ob,
    output logic [1:0]             state_ob
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } state_t;

    logic clk;
    logic rst_n;
    assign clk   = ClkRs_ix.clk;
    assign rst_n = ClkRs_ix.reset;

    // IC/EC slow-control bits carry no pattern information
    logic unused_ic_ec;
    assign unused_ic_ec = ^rx_frame_ib84[83:80];

    state_t        state;
    logic [79:0]   payload_q;
    logic          valid_q;
    logic [15:0]   expected;
    logic [7:0]    good_run;
    logic [7:0]    bad_run;

    logic [15:0]   w0, w1, w2, w3, w4;
    logic          consistent;
    logic          match;
    logic          counting;
    logic [7:0]    good_next;
    logic [7:0]    bad_next;

    assign w0 = payload_q[15:0];
    assign w1 = payload_q[31:16];
    assign w2 = payload_q[47:32];
    assign w3 = payload_q[63:48];
    assign w4 = payload_q[79:64];

    assign consistent = (w1 == w0 + 16'd1) && (w2 == w0 + 16'd2) &&
                        (w3 == w0 + 16'd3) && (w4 == w0 + 16'd4);
    assign match      = consistent && (w0 == expected);
    assign good_next  = (match && good_run != 8'd0) ? good_run + 8'd1 : 8'd1;
    assign bad_next   = bad_run + 8'd1;
    assign counting   = rx_ready_i && (state == LOCKED) && valid_q;
    assign state_ob   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            payload_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            payload_q <= rx_frame_ib84[79:0];
            valid_q   <= rx_valid_i;
        end
    end

    // Link-down is taken straight from rx_ready_i so the frame already in the
    // input register is dropped on the same edge that leaves LOCKED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            locked_o <= 1'b0;
            error_o  <= 1'b0;
            expected <= '0;
            good_run <= '0;
            bad_run  <= '0;
        end else begin
            error_o <= 1'b0;
            if (!rx_ready_i) begin
                state    <= IDLE;
                locked_o <= 1'b0;
                good_run <= '0;
                bad_run  <= '0;
            end else begin
                case (state)
                    IDLE: state <= SEARCH;
                    SEARCH: begin
                        if (valid_q) begin
                            if (consistent) begin
                                expected <= w0 + 16'd1;
                                good_run <= good_next;
                                if (good_next == 8'(LOCK_COUNT)) begin
                                    state    <= LOCKED;
                                    locked_o <= 1'b1;
                                    bad_run  <= '0;
                                end
                            end else begin
                                good_run <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (valid_q) begin
                            expected <= expected + 16'd1;
                            if (match) begin
                                bad_run <= '0;
                            end else begin
                                error_o <= 1'b1;
                                bad_run <= bad_next;
                                if (bad_next == 8'(LOSS_COUNT)) begin
                                    state    <= SEARCH;
                                    locked_o <= 1'b0;
                                    good_run <= '0;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_ob   <= '0;
            frame_cnt_ob <= '0;
        end else if (clear_i) begin
            err_cnt_ob   <= '0;
            frame_cnt_ob <= '0;
        end else if (counting) begin
            frame_cnt_ob <= frame_cnt_ob + FRAMECNT_W'(1);
            if (!match && err_cnt_ob != '1)
                err_cnt_ob <= err_cnt_ob + ERRCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_gbt_rx_pattern_checker.sv
// tb/tb_gbt_rx_pattern_checker.sv - directed self-checking bench for gbt_rx_pattern_checker
module tb_gbt_rx_pattern_checker;
    import gbt_rx_pkg::*;

    localparam int ERRCNT_W   = 3;
    localparam int FRAMECNT_W = 48;

    logic                  clk;
    logic                  rst_n;
    ckrs_t                 clk_rs;
    logic [83:0]           rx_frame;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  clear;
    logic                  locked;
    logic                  error;
    logic [ERRCNT_W-1:0]   err_cnt;
    logic [FRAMECNT_W-1:0] frame_cnt;
    logic [1:0]            state;

    int vectors;
    int miscompares;
    int seen_err;

    assign clk_rs = '{clk: clk, reset: rst_n};

    gbt_rx_pattern_checker #(
        .LOCK_COUNT (16),
        .LOSS_COUNT (4),
        .ERRCNT_W   (ERRCNT_W),
        .FRAMECNT_W (FRAMECNT_W)
    ) dut (
        .ClkRs_ix      (clk_rs),
        .rx_frame_ib84 (rx_frame),
        .rx_valid_i    (rx_valid),
        .rx_ready_i    (rx_ready),
        .clear_i       (clear),
        .locked_o      (locked),
        .error_o       (error),
        .err_cnt_ob    (err_cnt),
        .frame_cnt_ob  (frame_cnt),
        .state_ob      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one frame at a falling edge; on return, outputs reflect the previous frame.
    task automatic drive(input logic [15:0] w0, input logic v, input logic [79:0] flip);
        logic [15:0] a1, a2, a3, a4;
        a1 = w0 + 16'd1;
        a2 = w0 + 16'd2;
        a3 = w0 + 16'd3;
        a4 = w0 + 16'd4;
        rx_frame = {4'b1011, ({a4, a3, a2, a1, w0} ^ flip)};
        rx_valid = v;
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        seen_err    = 0;
        rst_n       = 1'b0;
        rx_frame    = '0;
        rx_valid    = 1'b0;
        rx_ready    = 1'b0;
        clear       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);

        rst_n    = 1'b1;
        rx_ready = 1'b1;
        drive(16'h0, 1'b0, '0);
        chk("linkup_search", 64'(state), 64'd1);

        for (int i = 0; i < 20; i++) begin
            drive(16'(i), 1'b1, '0);
            if (i == 15) chk("lock_not_yet", 64'(locked), 64'd0);
            if (i == 16) chk("lock_after_16", 64'(locked), 64'd1);
        end
        drive(16'h0, 1'b0, '0);
        chk("lock_state", 64'(state), 64'd2);
        chk("lock_frame_cnt", 64'(frame_cnt), 64'd4);
        chk("lock_err_cnt", 64'(err_cnt), 64'd0);

        drive(16'd20, 1'b1, 80'h1 << 37);
        chk("bit37_pre", 64'(error), 64'd0);
        drive(16'd21, 1'b1, '0);
        chk("bit37_pulse", 64'(error), 64'd1);
        chk("bit37_err_cnt", 64'(err_cnt), 64'd1);
        chk("bit37_locked", 64'(locked), 64'd1);
        drive(16'd22, 1'b1, '0);
        chk("bit37_next_ok", 64'(error), 64'd0);
        drive(16'h0, 1'b0, '0);
        chk("bit37_frame_cnt", 64'(frame_cnt), 64'd7);

        for (int j = 0; j < 4; j++) begin
            drive(16'h1000 + 16'(j), 1'b1, '0);
            if (j == 3) chk("loss_3rd_locked", 64'(locked), 64'd1);
        end
        drive(16'h0, 1'b0, '0);
        chk("loss_err_cnt", 64'(err_cnt), 64'd5);
        chk("loss_locked", 64'(locked), 64'd0);
        chk("loss_pulse", 64'(error), 64'd1);
        chk("loss_state", 64'(state), 64'd1);
        chk("loss_frame_cnt", 64'(frame_cnt), 64'd11);

        for (int k = 0; k < 16; k++) drive(16'h2000 + 16'(k), 1'b1, '0);
        drive(16'h0, 1'b0, '0);
        chk("relock", 64'(locked), 64'd1);
        chk("relock_frame_cnt", 64'(frame_cnt), 64'd11);

        drive(16'h2010, 1'b1, 80'h4);
        drive(16'h2011, 1'b1, '0);
        drive(16'h2012, 1'b1, 80'h4);
        drive(16'h2013, 1'b1, '0);
        drive(16'h2014, 1'b1, 80'h4);
        drive(16'h2015, 1'b1, '0);
        chk("sat_pulse", 64'(error), 64'd1);
        chk("sat_err_cnt", 64'(err_cnt), 64'd7);
        drive(16'h0, 1'b0, '0);
        chk("sat_hold", 64'(err_cnt), 64'd7);
        chk("sat_frame_cnt", 64'(frame_cnt), 64'd17);
        chk("sat_locked", 64'(locked), 64'd1);

        drive(16'h2016, 1'b1, 80'h10000);
        clear = 1'b1;
        drive(16'h2017, 1'b1, '0);
        clear = 1'b0;
        chk("clr_pulse", 64'(error), 64'd1);
        chk("clr_err_cnt", 64'(err_cnt), 64'd0);
        chk("clr_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("clr_locked", 64'(locked), 64'd1);
        drive(16'h0, 1'b0, '0);
        chk("clr_after_err", 64'(err_cnt), 64'd0);
        chk("clr_after_frame", 64'(frame_cnt), 64'd1);

        rx_ready = 1'b0;
        drive(16'h2018, 1'b1, '0);
        chk("rdy_drop_state", 64'(state), 64'd0);
        chk("rdy_drop_locked", 64'(locked), 64'd0);
        rx_ready = 1'b1;
        drive(16'h0, 1'b0, '0);
        chk("rdy_up_state", 64'(state), 64'd1);
        chk("rdy_discard", 64'(frame_cnt), 64'd1);

        for (int k = 0; k < 16; k++) drive(16'hFFEC + 16'(k), 1'b1, '0);
        drive(16'h0, 1'b0, '0);
        chk("wrap_lock", 64'(locked), 64'd1);
        for (int j = 0; j < 10; j++) begin
            if (j % 2 == 0) drive(16'hFFFC + 16'(j / 2), 1'b1, '0);
            else            drive(16'h5555, 1'b0, 80'h1);
            if (error) seen_err++;
        end
        drive(16'h0, 1'b0, '0);
        if (error) seen_err++;
        chk("wrap_no_pulse", 64'(seen_err), 64'd0);
        chk("wrap_err_cnt", 64'(err_cnt), 64'd0);
        chk("wrap_frame_cnt", 64'(frame_cnt), 64'd6);
        drive(16'h0001, 1'b1, '0);
        drive(16'h0, 1'b0, '0);
        chk("wrap_expected", 64'(error), 64'd0);
        chk("wrap_frame_cnt2", 64'(frame_cnt), 64'd7);
        chk("wrap_locked", 64'(locked), 64'd1);

        drive(16'h0002, 1'b1, '0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", 64'(state), 64'd0);
        chk("arst_locked", 64'(locked), 64'd0);
        chk("arst_error", 64'(error), 64'd0);
        chk("arst_err_cnt", 64'(err_cnt), 64'd0);
        chk("arst_frame_cnt", 64'(frame_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gbt_rx_pattern_checker.md
Name: gbt_rx_pattern_checker

Overview:
Link-verification receiver for the GBT frame stream delivered by gbt_xu5 in the 40 MHz frame clock domain. It checks received frames against the counter pattern produced by the far-end link tester and locks onto that pattern. It counts frame errors and reports lock status to the MCoi diagnostic registers. It is the checking end of the pattern link test; it never drives the GBT TX path.

Parameters:
LOCK_COUNT, 16, consecutive good valid frames required to declare lock (1..255)
LOSS_COUNT, 4, consecutive bad valid frames in LOCKED that drop lock (1..255)
ERRCNT_W, 32, width of error counter (saturating)
FRAMECNT_W, 48, width of checked-frame counter (wrapping)

Ports:
ClkRs_ix  input  ckrs_t  .clk = 40 MHz frame clock; .reset = reset, asynchronous, active-low
rx_frame_ib84  input  84  received GBT frame: [83:82] IC, [81:80] EC, [79:0] payload
rx_valid_i  input  1  frame valid for this clock (GBT data-valid header)
rx_ready_i  input  1  GBT link ready/aligned
clear_i  input  1  synchronous clear of both counters
locked_o  output  1  pattern lock
error_o  output  1  one-cycle pulse per mismatching frame while LOCKED
err_cnt_ob  output  ERRCNT_W  accumulated errors, saturates at all-ones
frame_cnt_ob  output  FRAMECNT_W  valid frames checked while LOCKED, wraps
state_ob  output  2  FSM state: 0 IDLE, 1 SEARCH, 2 LOCKED

Behaviour:
- Reset (ClkRs_ix.reset low, async): state IDLE, all outputs 0, expected word, good_run, bad_run = 0.
- Pattern: payload split into five 16-bit words w[k] = payload[16k+15:16k]. A frame is consistent if w[k] == w[0]+k mod 2^16 for k = 1..4. IC/EC bits are ignored.
- Inputs are registered once. All outputs are registered; error_o, counters and locked_o update 2 clocks after the frame is present on the inputs.
- Frames with rx_valid_i = 0 are ignored: no compare, expected word not advanced, runs unchanged.
- IDLE: entered from any state within 1 clock when rx_ready_i = 0. Counters hold; locked_o = 0. Leave to SEARCH when rx_ready_i = 1.
- SEARCH, per valid frame:
  - Consistent and w[0] == expected with good_run > 0: good_run++, expected = w[0]+1.
  - Consistent otherwise: reseed, good_run = 1, expected = w[0]+1.
  - Inconsistent: good_run = 0.
  - When good_run reaches LOCK_COUNT: go to LOCKED, bad_run = 0. LOCK_COUNT = 1 locks on the first consistent frame.
  - No error_o and no counting in SEARCH.
- LOCKED, per valid frame:
  - frame_cnt++.
  - Good means consistent and w[0] == expected. Good: bad_run = 0.
  - Otherwise: error_o pulses, err_cnt++ (saturating), bad_run++.
  - expected = expected+1 on every valid frame, good or bad.
  - When bad_run reaches LOSS_COUNT: go to SEARCH, good_run = 0, locked_o = 0 on the same edge that registers the last error.
- Wrap: expected and w[0] wrap 0xFFFF -> 0x0000 with no error.
- clear_i: zeroes err_cnt and frame_cnt on the next edge. If clear_i coincides with an increment, the result is 0. FSM, locked_o, runs and error_o are unaffected.
- rx_ready_i deassertion mid-lock: go to IDLE. A frame in the input register that cycle is discarded. Re-lock requires the full LOCK_COUNT.

Test Plan:
- Link up, 20 valid frames seeded at w[0] = 0x0000 -> locked_o = 1 after the 16th frame (+2 clk); frame_cnt = 4 after the 20th; err_cnt = 0.
- Locked, corrupt payload bit 37 in one frame -> one error_o pulse, err_cnt = 1, locked_o stays 1, next correct frame gives no error.
- Locked, 4 consecutive frames with wrong w[0] -> err_cnt = 4, locked_o = 0 on the 4th; then 16 correct frames -> relock.
- Seed 0xFFFC, 10 frames with rx_valid_i toggling 1/0 -> no errors across the 0xFFFF->0x0000 wrap; invalid cycles do not advance expected.
- clear_i asserted in the same cycle an error is counted -> err_cnt = 0 next clock, locked_o unchanged; err_cnt preloaded near all-ones saturates, no wrap.
- rx_ready_i dropped while LOCKED, and async reset asserted mid-frame -> state 0, locked_o = 0 within 1 clock (reset: immediately, all outputs 0).
